// File: rtl/lj16_pkg.sv
// Shared widths, frame layout and sample-pair type for the LJ16 serial-audio transmitter.
package lj16_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    localparam logic LRCK_LEFT = 1'b0;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/lj16_bck_gen.sv
// Bit-clock divider: bck toggles every CLK_DIV clks; strobes fire in the clk whose edge toggles bck.
// No backpressure; free-running while out of reset.
module lj16_bck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bck,
    output logic bck_rise,
    output logic bck_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tc;

    // Strobes are combinational so consumers update on the same edge that toggles bck.
    assign tc       = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bck_rise = tc & ~bck;
    assign bck_fall = tc & bck;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/lj16_tx.sv
// LJ16 transmitter: one-deep holding register feeds a 32-bit frame on BCK falls; in_ready = hold empty.
// Macro LJ16_TX_HOLD_LAST_EN: underrun frames repeat the last loaded pair instead of sending zeros.
module lj16_tx
    import lj16_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                bck,
    output logic                lrck,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);

    logic                  bck_rise_unused;
    logic                  bck_fall;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_nxt;
    logic [FRAME_BITS-1:0] shifter;
    logic [FRAME_BITS-1:0] load_val;
    sample_pair_t          hold;
    logic                  hold_full;
    logic                  load;

    lj16_bck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bck_gen (
        .clk      (clk),
        .rst      (rst),
        .bck      (bck),
        .bck_rise (bck_rise_unused),
        .bck_fall (bck_fall)
    );

    assign bit_nxt  = bit_cnt + BIT_CNT_W'(1);
    assign load     = bck_fall && (bit_nxt == '0);
    assign in_ready = ~hold_full;

`ifdef LJ16_TX_HOLD_LAST_EN
    sample_pair_t last_pair;

    assign load_val = hold_full ? hold : last_pair;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pair <= '0;
        end else if (load && hold_full) begin
            last_pair <= hold;
        end
    end
`else
    assign load_val = hold_full ? hold : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '1;
            shifter     <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            lrck        <= ~LRCK_LEFT;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (bck_fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= bit_nxt[BIT_CNT_W-1];
                if (load) begin
                    shifter     <= load_val;
                    sdata       <= load_val[FRAME_BITS-1];
                    frame_start <= 1'b1;
                    underrun    <= ~hold_full;
                    hold_full   <= 1'b0;
                end else begin
                    // With a 32-bit frame, MSB-first position 31-n is simply ~n.
                    sdata <= shifter[~bit_nxt];
                end
            end
            // Placed after the load so a same-clk accept refills hold for the next frame.
            if (in_valid && !hold_full) begin
                hold.left  <= in_left;
                hold.right <= in_right;
                hold_full  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lj16_tx.sv
// Directed bench for lj16_tx: scoreboard of expected frames checked bit-by-bit on BCK rises.
module tb_lj16_tx;
    import lj16_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        und;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_ready, bck, lrck, sdata, frame_start, underrun;
    logic        in_ready2, bck2, lrck2, sdata2, fs2, und2;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    lj16_tx #(.CLK_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_left     (in_left),
        .in_right    (in_right),
        .bck         (bck),
        .lrck        (lrck),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    lj16_tx #(.CLK_DIV(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (1'b1),
        .in_ready    (in_ready2),
        .in_left     (16'h8001),
        .in_right    (16'h7FFE),
        .bck         (bck2),
        .lrck        (lrck2),
        .sdata       (sdata2),
        .frame_start (fs2),
        .underrun    (und2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < limit);
    endtask

    // Scoreboard monitor: collects 32 bits per frame on BCK rises.
    logic        rst_q = 1'b1;
    logic        bck_q = 1'b0;
    logic        collecting = 1'b0;
    logic        cur_und = 1'b0;
    int          nbits = 0;
    int          und_cnt = 0;
    logic [31:0] got_d = '0;
    logic [31:0] got_lr = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst_q) begin
            if (collecting && exp_q.size() > 0) mon_e = exp_q.pop_front();
            collecting = 1'b0;
        end else begin
            if (underrun) und_cnt++;
            if (frame_start) begin
                collecting = 1'b1;
                nbits      = 0;
                cur_und    = underrun;
            end else if (collecting && bck && !bck_q) begin
                got_d  = {got_d[30:0], sdata};
                got_lr = {got_lr[30:0], lrck};
                nbits++;
                if (nbits == 32) begin
                    collecting = 1'b0;
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("frame_data", got_d, mon_e.data);
                        chk("frame_lrck", got_lr, 32'h0000FFFF);
                        chk("frame_underrun", 32'(cur_und), 32'(mon_e.und));
                    end
                end
            end
        end
        rst_q = rst;
        bck_q = bck;
    end

    // CLK_DIV=2 instance: lrck/sdata may only move on a BCK fall; BCK period 4 clks.
    logic rst_q2 = 1'b1;
    logic bck2_q = 1'b0;
    logic lrck2_q = 1'b1;
    logic sdata2_q = 1'b0;
    int   cyc = 0;
    int   last_rise = -1;

    always @(negedge clk) begin
        cyc++;
        if (rst_q2) begin
            last_rise = -1;
        end else begin
            if (lrck2 !== lrck2_q || sdata2 !== sdata2_q)
                chk("d2_change_on_fall", 32'({bck2_q, bck2}), 32'b10);
            if (bck2 && !bck2_q) begin
                if (last_rise >= 0) chk("d2_bck_period", 32'(cyc - last_rise), 32'd4);
                last_rise = cyc;
            end
        end
        rst_q2   = rst;
        bck2_q   = bck2;
        lrck2_q  = lrck2;
        sdata2_q = sdata2;
    end

    initial begin
        exp_t        e;
        int          n;
        int          n_acc;
        int          last_c;
        logic        acc;
        logic [31:0] cur;
        logic [31:0] last_pair;

        last_pair = '0;

        // Reset values, then an idle first frame after release.
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_bck", 32'(bck), 32'd0);
        chk("rst_lrck", 32'(lrck), 32'd1);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        e.data = '0; e.und = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        rst = 1'b0;
        wait_fs(20, n);
        chk("t1_fs_seen", 32'(frame_start), 32'd1);
        chk("t1_first_fs_clks", 32'(n), 32'd8);
        chk("t1_underrun_with_fs", 32'(underrun), 32'd1);
        wait_fs(300, n);
        chk("t1_frame_clks", 32'(n), 32'd256);

        // Pair offered before the first load.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_left = 16'hA5C3; in_right = 16'h0F01;
        e.data = 32'hA5C3_0F01; e.und = 1'b0;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        chk("t2_ready_low_when_full", 32'(in_ready), 32'd0);
        wait_fs(20, n);
        chk("t2_fs_clks", 32'(n + 2), 32'd8);
        chk("t2_no_underrun", 32'(underrun), 32'd0);
        chk("t2_ready_on_load", 32'(in_ready), 32'd1);

        // Continuous in_valid with an incrementing pattern.
        und_cnt = 0; n_acc = 0; last_c = 0;
        cur = 32'h1000_2000;
        in_valid = 1'b1; {in_left, in_right} = cur;
        for (int c = 0; c < 1100; c++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                e.data = cur; e.und = 1'b0;
                exp_q.push_back(e);
                if (n_acc > 0) chk("t3_accept_gap", 32'(c - last_c), 32'd256);
                last_c    = c;
                n_acc++;
                last_pair = cur;
                cur       = cur + 32'h0001_0003;
                {in_left, in_right} = cur;
            end
        end
        in_valid = 1'b0;
        chk("t3_accepts", 32'(n_acc), 32'd5);
        wait_fs(300, n);
        chk("t3_last_fs_seen", 32'(frame_start), 32'd1);
        chk("t3_last_no_underrun", 32'(underrun), 32'd0);
        chk("t3_underrun_count", 32'(und_cnt), 32'd0);

        // in_valid asserted exactly on the load clk with hold empty.
        repeat (255) tick();
        in_valid = 1'b1; {in_left, in_right} = 32'hBEEF_0042;
        tick();
        in_valid = 1'b0;
        chk("t4_fs_on_load", 32'(frame_start), 32'd1);
        chk("t4_underrun", 32'(underrun), 32'd1);
        chk("t4_accepted_same_clk", 32'(in_ready), 32'd0);
`ifdef LJ16_TX_HOLD_LAST_EN
        e.data = last_pair;
`else
        e.data = '0;
`endif
        e.und = 1'b1;
        exp_q.push_back(e);
        e.data = 32'hBEEF_0042; e.und = 1'b0;
        exp_q.push_back(e);
        wait_fs(300, n);
        chk("t4_next_frame_clks", 32'(n), 32'd256);
        chk("t4_next_no_underrun", 32'(underrun), 32'd0);

        // One more pair, then reset at bit 20 of its frame.
        in_valid = 1'b1; {in_left, in_right} = 32'h7FFF_8800;
        tick();
        in_valid = 1'b0;
        e.data = 32'h7FFF_8800; e.und = 1'b0;
        exp_q.push_back(e);
        wait_fs(300, n);
        chk("t5_fs_clks", 32'(n), 32'd255);
        in_valid = 1'b1; {in_left, in_right} = 32'h1111_2222;
        tick();
        in_valid = 1'b0;
        chk("t5_hold_full", 32'(in_ready), 32'd0);
        repeat (163) tick();
        chk("t5_pre_rst_bck", 32'(bck), 32'd1);
        chk("t5_pre_rst_sdata", 32'(sdata), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_rst_bck", 32'(bck), 32'd0);
        chk("t5_rst_lrck", 32'(lrck), 32'd1);
        chk("t5_rst_sdata", 32'(sdata), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        e.data = '0; e.und = 1'b1;
        exp_q.push_back(e);
        wait_fs(20, n);
        chk("t5_fs_after_release", 32'(n), 32'd8);
        chk("t5_hold_discarded", 32'(underrun), 32'd1);
        wait_fs(300, n);
        chk("t5_frame_clks", 32'(n), 32'd256);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
